// File: rtl/pulse_pkg.sv
// Shared types and default sizing for the pulse stretcher and its counter.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CNT_W_DEF      = 8;
  localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; shared by the HOLD and GAP phases.
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && !zero)
      count <= count - W'(1);
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a level of programmable length, with an
// optional retrigger mode, consumer early-termination and a forced low gap.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int RETRIG     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] len_in,
  input  logic             ack_in,
  output logic             level_out,
  output logic             busy_out,
  output logic             dropped_out
);

  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam state_t           EXIT_ST  = HAS_GAP ? GAP : IDLE;

  state_t           state, state_nxt;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val, count, hold_len;
  logic             last, drop;
  logic             level_nxt, busy_nxt, dropped_nxt;

  // A zero length still produces a one-cycle level.
  assign hold_len = (len_in == '0) ? CNT_W'(1) : len_in;

  // The counter holds the cycles remaining including the current one.
  assign last = cnt_zero || (count == CNT_W'(1));

  down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = hold_len;
    cnt_en    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pulse_in) begin
          state_nxt = HOLD;
          cnt_load  = 1'b1;
        end
      end
      HOLD: begin
        if (ack_in) begin
          state_nxt = EXIT_ST;
          cnt_load  = HAS_GAP;
          cnt_val   = GAP_LOAD;
          drop      = pulse_in;
        end else if (pulse_in && (RETRIG != 0 || (!HAS_GAP && last))) begin
          // Retrigger, or seamless back-to-back restart when there is no gap.
          cnt_load = 1'b1;
        end else begin
          drop = pulse_in;
          if (last) begin
            state_nxt = EXIT_ST;
            cnt_load  = HAS_GAP;
            cnt_val   = GAP_LOAD;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      GAP: begin
        drop = pulse_in;
        if (last)
          state_nxt = IDLE;
        else
          cnt_en = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    level_nxt   = (state_nxt == HOLD);
    busy_nxt    = (state_nxt != IDLE);
    dropped_nxt = drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_out   <= 1'b0;
      busy_out    <= 1'b0;
      dropped_out <= 1'b0;
    end else begin
      level_out   <= level_nxt;
      busy_out    <= busy_nxt;
      dropped_out <= dropped_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default, retrigger and no-gap variants share stimulus.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic [7:0] len_in = 8'd0;
  logic       ack_in = 1'b0;

  logic lvl_a, busy_a, drop_a;  // RETRIG=0, GAP=2
  logic lvl_r, busy_r, drop_r;  // RETRIG=1, GAP=2
  logic lvl_g, busy_g, drop_g;  // RETRIG=0, GAP=0

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(2), .RETRIG(0)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len_in(len_in), .ack_in(ack_in),
    .level_out(lvl_a), .busy_out(busy_a), .dropped_out(drop_a));

  pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(2), .RETRIG(1)) dut_rt (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len_in(len_in), .ack_in(ack_in),
    .level_out(lvl_r), .busy_out(busy_r), .dropped_out(drop_r));

  pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(0), .RETRIG(0)) dut_g0 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len_in(len_in), .ack_in(ack_in),
    .level_out(lvl_g), .busy_out(busy_g), .dropped_out(drop_g));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs for the next posedge, return at the following negedge.
  task automatic tick(input logic p, input logic [7:0] l, input logic a);
    pulse_in = p;
    len_in   = l;
    ack_in   = a;
    @(negedge clk);
    pulse_in = 1'b0;
    len_in   = 8'd0;
    ack_in   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic sel_lvl(input int w);
    case (w)
      0:       return lvl_a;
      1:       return lvl_r;
      default: return lvl_g;
    endcase
  endfunction

  // Counts further cycles the selected level stays high, starting from the current cycle.
  task automatic count_high(input int w, output int n);
    n = 0;
    while (sel_lvl(w) === 1'b1 && n < 300) begin
      n++;
      tick(1'b0, 8'd0, 1'b0);
    end
  endtask

  initial begin
    int n;
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    @(negedge clk);
    chk("reset_level", lvl_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_dropped", drop_a, 0);
    do_reset();

    // Basic L=3 hold: level cycles 1-3, busy 1-5, next pulse accepted at edge 6.
    tick(1, 8'd3, 0);
    chk("l3_c1_level", lvl_a, 1);
    chk("l3_c1_busy", busy_a, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("l3_c3_level", lvl_a, 1);
    chk("g0_c3_level", lvl_g, 1);
    tick(0, 0, 0);
    chk("l3_c4_level", lvl_a, 0);
    chk("l3_c4_busy", busy_a, 1);
    chk("g0_c4_busy", busy_g, 0);
    tick(0, 0, 0);
    chk("l3_c5_busy", busy_a, 1);
    tick(0, 0, 0);
    chk("l3_c6_busy", busy_a, 0);
    tick(1, 8'd2, 0);
    chk("l3_reaccept_level", lvl_a, 1);
    chk("l3_reaccept_dropped", drop_a, 0);
    do_reset();

    // Length boundaries.
    tick(1, 8'd0, 0);
    count_high(0, n);
    chk("len0_high_cycles", n, 1);
    do_reset();
    tick(1, 8'd255, 0);
    count_high(0, n);
    chk("len255_high_cycles", n, 255);
    do_reset();

    // Pulse during hold, L=5, second pulse at edge 2.
    tick(1, 8'd5, 0);
    tick(0, 0, 0);
    tick(1, 8'd9, 0);
    chk("nort_c3_dropped", drop_a, 1);
    chk("rt_c3_dropped", drop_r, 0);
    tick(0, 0, 0);
    chk("nort_c4_dropped", drop_a, 0);
    chk("nort_c4_level", lvl_a, 1);
    tick(0, 0, 0);
    chk("nort_c5_level", lvl_a, 1);
    tick(0, 0, 0);
    chk("nort_c6_level", lvl_a, 0);
    do_reset();

    // Retrigger: L=5 at edge 0, L=4 at edge 3 -> high cycles 1-7.
    tick(1, 8'd5, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(1, 8'd4, 0);
    chk("nort_retrig_dropped", drop_a, 1);
    count_high(1, n);
    chk("rt_high_from_c4", n, 4);
    do_reset();

    // Ack at edge 2 of an L=10 hold, then a pulse during the gap.
    tick(0, 0, 1);
    chk("ack_idle_busy", busy_a, 0);
    tick(1, 8'd10, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("ack_c3_level", lvl_a, 0);
    chk("ack_c3_busy", busy_a, 1);
    chk("ack_g0_c3_busy", busy_g, 0);
    tick(1, 8'd3, 0);
    chk("gap_pulse_dropped", drop_a, 1);
    chk("gap_pulse_level", lvl_a, 0);
    tick(0, 0, 0);
    chk("gap_end_busy", busy_a, 0);
    do_reset();
    tick(1, 8'd10, 0);
    tick(0, 0, 0);
    tick(1, 8'd5, 1);
    chk("ack_pulse_dropped", drop_a, 1);
    chk("ack_pulse_level", lvl_a, 0);
    do_reset();

    // Back-to-back with no gap: pulse on final hold cycle keeps level high.
    tick(1, 8'd2, 0);
    tick(0, 0, 0);
    tick(1, 8'd3, 0);
    chk("b2b_g0_dropped", drop_g, 0);
    chk("lastcyc_gap_dropped", drop_a, 1);
    chk("lastcyc_gap_level", lvl_a, 0);
    count_high(2, n);
    chk("b2b_g0_high", n, 3);
    do_reset();

    // Asynchronous reset mid-hold, then a fresh L=2 pulse on the first edge.
    tick(1, 8'd10, 0);
    tick(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level", lvl_a, 0);
    chk("async_rst_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1, 8'd2, 0);
    count_high(0, n);
    chk("post_rst_high", n, 2);
    do_reset();

    // Reset mid-gap leaves nothing behind.
    tick(1, 8'd1, 0);
    tick(0, 0, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 0);
    chk("post_gap_rst_busy", busy_a, 0);
    chk("post_gap_rst_dropped", drop_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
